// File: rtl/uart_rx_pkg.sv
// UART receive controller shared types.
// FSM state encoding and the supported oversampling ratios.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int unsigned PS_8  = 8;
    localparam int unsigned PS_16 = 16;
    localparam int unsigned PS_32 = 32;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and data bit counter.
// bit_end marks the last oversampling edge of the current bit.
module uart_rx_edge_bit_cnt #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  bit_inc,
    input  logic [PRESCALE_W-1:0] ps_q,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]      bit_cnt,
    output logic                  bit_end
);

    assign bit_end = en && (edge_cnt == ps_q - 1'b1);

    // Edge count wraps at bit end; bit count advances only when asked.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (en) begin
            edge_cnt <= bit_end ? '0 : edge_cnt + 1'b1;
            if (bit_end && bit_inc) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else begin
            edge_cnt <= '0;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, mid-bit sampling,
// deserializer strobes, parity/stop checks and frame-valid pulse.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6,
    localparam int BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_in,
    input  logic                  sampled_data,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  sample_enable,
    output logic                  deser_en,
    output logic [BIT_W-1:0]      bit_idx,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    state_t                  state;
    state_t                  state_nx;
    logic [PRESCALE_W-1:0]   ps_q;
    logic [PRESCALE_W-1:0]   edge_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    bit_end;
    logic                    start_det;
    logic                    last_bit;
    logic                    acc;

    assign busy          = (state != IDLE);
    assign start_det     = (state == IDLE) && !rx_in;
    assign sample_enable = busy && (edge_cnt == (ps_q >> 1) - 1'b1);
    assign last_bit      = (bit_cnt == BIT_W'(DATA_W - 1));

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_W      (BIT_W)
    ) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (start_det),
        .en       (busy),
        .bit_inc  (state == DATA),
        .ps_q     (ps_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and strobe outputs.
    always_comb begin
        state_nx   = state;
        deser_en   = 1'b0;
        data_valid = 1'b0;
        bit_idx    = bit_cnt;
        case (state)
            IDLE: begin
                if (!rx_in) state_nx = START;
            end
            START: begin
                if (sample_enable && sampled_data) begin
                    state_nx = IDLE;
                end else if (bit_end) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                deser_en = sample_enable;
                if (bit_end && last_bit) begin
                    state_nx = par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) state_nx = STOP;
            end
            STOP: begin
                data_valid = bit_end && !par_err && !stp_err;
                if (bit_end) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Prescale latch, parity accumulator and error flags.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ps_q    <= '0;
            acc     <= 1'b0;
            par_err <= 1'b0;
            stp_err <= 1'b0;
        end else if (start_det) begin
            ps_q    <= prescale;
            acc     <= 1'b0;
            par_err <= 1'b0;
            stp_err <= 1'b0;
        end else if (sample_enable) begin
            case (state)
                DATA:    acc     <= acc ^ sampled_data;
                PARITY:  par_err <= sampled_data ^ acc ^ par_typ;
                STOP:    stp_err <= ~sampled_data;
                default: ;
            endcase
        end
    end

endmodule
